// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- sequential 16-bit ALU for the accumulator datapath.
//
// Single-cycle ops (ADD, SUB, AND, OR, NOT, SHL, SHR, DIV by zero, and the
// reserved codes) complete on the start edge. MPY (16-step shift-add) and
// DIV (16-step restoring divide) spend 16 further edges in RUN. Every
// completion passes through DONE for exactly one cycle. The block then
// returns to IDLE.
//
// Ports
//   clk         in   1  system clock, rising-edge active
//   rst         in   1  asynchronous reset, active low
//   start       in   1  operation request, sampled only in IDLE
//   op          in   4  operation code, sampled with start
//   ACC_NUM     in  16  operand A, sampled with start
//   BR_NUM      in  16  operand B, sampled with start
//   ALU_result  out 16  low word / quotient, held between completions
//   ALU_hi      out 16  high product / remainder, written by MPY/DIV only
//   busy        out  1  high in RUN and DONE
//   done        out  1  high for the single DONE cycle
//   ZF NF CF OF DZ out 1 each  registered flags
//
// Op codes
//   0000 ADD  0001 SUB  0010 AND  0011 OR   0100 NOT
//   0101 SHL  0110 SHR  0111 MPY  1000 DIV  1001-1111 reserved
// -----------------------------------------------------------------------------
module alu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [15:0] ACC_NUM,
    input  logic [15:0] BR_NUM,
    output logic [15:0] ALU_result,
    output logic [15:0] ALU_hi,
    output logic        busy,
    output logic        done,
    output logic        ZF,
    output logic        NF,
    output logic        CF,
    output logic        OF,
    output logic        DZ
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
    localparam logic [3:0] OP_MPY = 4'b0111;
    localparam logic [3:0] OP_DIV = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Latched operation context for the multi-cycle ops
    logic        r_is_div;
    logic [15:0] r_opnd;     // multiplicand (MPY) or divisor (DIV)
    logic [3:0]  r_cnt;
    logic [15:0] r_wh;       // working high word: partial product / remainder
    logic [15:0] r_wl;       // working low word: multiplier / dividend->quotient

    // Registered outputs
    logic [15:0] r_result;
    logic [15:0] r_hi;
    logic        r_zf;
    logic        r_nf;
    logic        r_cf;
    logic        r_of;
    logic        r_dz;

    // Request decode
    logic        w_accept;
    logic        w_multi;

    // Single-cycle datapath
    logic [16:0] w_add;
    logic [15:0] w_sub;
    logic [15:0] w_res;
    logic        w_cf;
    logic        w_of;
    logic        w_dz;
    logic        w_hi_wr;
    logic [15:0] w_hi;

    // Iteration datapath
    logic [16:0] w_sum;
    logic [15:0] w_mh;
    logic [15:0] w_ml;
    logic [16:0] w_sh;
    logic        w_ge;
    logic [15:0] w_diff;
    logic [15:0] w_dh;
    logic [15:0] w_dl;
    logic [15:0] w_nh;
    logic [15:0] w_nl;
    logic        w_last;

    assign w_accept = (r_state == S_IDLE) && start;
    // DIV by zero is resolved on the start edge and never enters RUN
    assign w_multi  = (op == OP_MPY) || ((op == OP_DIV) && (BR_NUM != 16'h0000));
    assign w_last   = (r_state == S_RUN) && (r_cnt == 4'd15);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_multi ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (r_cnt == 4'd15) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output logic
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN: begin
                busy = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Single-cycle result and flags, computed straight from the inputs so
    // they can be written on the start edge.
    // -------------------------------------------------------------------------
    assign w_add = {1'b0, ACC_NUM} + {1'b0, BR_NUM};
    assign w_sub = ACC_NUM - BR_NUM;

    always_comb begin
        w_res   = '0;
        w_cf    = 1'b0;
        w_of    = 1'b0;
        w_dz    = 1'b0;
        w_hi_wr = 1'b0;
        w_hi    = ACC_NUM;
        case (op)
            OP_ADD: begin
                w_res = w_add[15:0];
                w_cf  = w_add[16];
                w_of  = (ACC_NUM[15] == BR_NUM[15]) && (w_add[15] != ACC_NUM[15]);
            end
            OP_SUB: begin
                w_res = w_sub;
                w_cf  = (ACC_NUM < BR_NUM);
                w_of  = (ACC_NUM[15] != BR_NUM[15]) && (w_sub[15] != ACC_NUM[15]);
            end
            OP_AND: begin
                w_res = ACC_NUM & BR_NUM;
            end
            OP_OR: begin
                w_res = ACC_NUM | BR_NUM;
            end
            OP_NOT: begin
                w_res = ~ACC_NUM;
            end
            OP_SHL: begin
                w_res = {ACC_NUM[14:0], 1'b0};
                w_cf  = ACC_NUM[15];
            end
            OP_SHR: begin
                w_res = {1'b0, ACC_NUM[15:1]};
                w_cf  = ACC_NUM[0];
            end
            OP_DIV: begin
                // Only reached on the single-cycle path when B == 0
                w_res   = 16'hFFFF;
                w_hi    = ACC_NUM;
                w_hi_wr = 1'b1;
                w_dz    = 1'b1;
            end
            default: begin
                // Reserved codes: zero result, ALU_hi untouched
                w_res = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // One iteration of each multi-cycle algorithm.
    //
    // MPY: {wh,wl} starts as {0,B}; each step adds A to wh when wl[0] is set
    //      and shifts the 33-bit {carry,wh,wl} right by one. After 16 steps
    //      {wh,wl} = A*B.
    // DIV: {wh,wl} starts as {0,A}; each step shifts the next dividend bit
    //      into the remainder, subtracts B when it fits and shifts the
    //      quotient bit into wl. After 16 steps wh = rem, wl = quotient.
    // -------------------------------------------------------------------------
    assign w_sum  = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_opnd} : 17'd0);
    assign w_mh   = w_sum[16:1];
    assign w_ml   = {w_sum[0], r_wl[15:1]};

    assign w_sh   = {r_wh, r_wl[15]};
    assign w_ge   = (w_sh >= {1'b0, r_opnd});
    // When the divisor fits, the true difference is below the divisor and
    // therefore fits in 16 bits.
    assign w_diff = w_sh[15:0] - r_opnd;
    assign w_dh   = w_ge ? w_diff : w_sh[15:0];
    assign w_dl   = {r_wl[14:0], w_ge};

    assign w_nh   = r_is_div ? w_dh : w_mh;
    assign w_nl   = r_is_div ? w_dl : w_ml;

    // -------------------------------------------------------------------------
    // Datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_div <= 1'b0;
            r_opnd   <= '0;
            r_cnt    <= '0;
            r_wh     <= '0;
            r_wl     <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_zf     <= 1'b0;
            r_nf     <= 1'b0;
            r_cf     <= 1'b0;
            r_of     <= 1'b0;
            r_dz     <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            if (w_multi) begin
                r_is_div <= (op == OP_DIV);
                r_opnd   <= (op == OP_DIV) ? BR_NUM : ACC_NUM;
                r_wh     <= '0;
                r_wl     <= (op == OP_DIV) ? ACC_NUM : BR_NUM;
            end else begin
                r_result <= w_res;
                r_zf     <= (w_res == 16'h0000);
                r_nf     <= w_res[15];
                r_cf     <= w_cf;
                r_of     <= w_of;
                r_dz     <= w_dz;
                if (w_hi_wr) begin
                    r_hi <= w_hi;
                end
            end
        end else if (r_state == S_RUN) begin
            r_wh  <= w_nh;
            r_wl  <= w_nl;
            r_cnt <= r_cnt + 4'd1;
            // Outputs only see the final iteration's values
            if (w_last) begin
                r_result <= w_nl;
                r_hi     <= w_nh;
                r_zf     <= (w_nl == 16'h0000);
                r_nf     <= w_nl[15];
                r_cf     <= r_is_div ? 1'b0 : (w_nh != 16'h0000);
                r_of     <= r_is_div ? 1'b0 : (w_nh != 16'h0000);
                r_dz     <= 1'b0;
            end
        end
    end

    assign ALU_result = r_result;
    assign ALU_hi     = r_hi;
    assign ZF         = r_zf;
    assign NF         = r_nf;
    assign CF         = r_cf;
    assign OF         = r_of;
    assign DZ         = r_dz;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [15:0] ACC_NUM;
    logic [15:0] BR_NUM;
    logic [15:0] ALU_result;
    logic [15:0] ALU_hi;
    logic        busy;
    logic        done;
    logic        ZF, NF, CF, OF, DZ;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    alu_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .ACC_NUM    (ACC_NUM),
        .BR_NUM     (BR_NUM),
        .ALU_result (ALU_result),
        .ALU_hi     (ALU_hi),
        .busy       (busy),
        .done       (done),
        .ZF         (ZF),
        .NF         (NF),
        .CF         (CF),
        .OF         (OF),
        .DZ         (DZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outcome of one operation, from plain arithmetic
    typedef struct packed {
        logic [15:0] res;
        logic [15:0] hi;
        bit          hi_wr;
        bit          zf, nf, cf, of, dz;
        bit          multi;
    } exp_t;

    function automatic exp_t model_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        int unsigned ua, ub;
        int          sa, sb, s;
        logic [31:0] p;
        e  = '0;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            4'd0: begin
                p = ua + ub;
                e.res = p[15:0];
                e.cf = (ua + ub) > 65535;
                s = sa + sb;
                e.of = (s > 32767) || (s < -32768);
            end
            4'd1: begin
                e.res = a - b;
                e.cf = ua < ub;
                s = sa - sb;
                e.of = (s > 32767) || (s < -32768);
            end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = ~a;
            4'd5: begin e.res = a << 1; e.cf = a[15]; end
            4'd6: begin e.res = a >> 1; e.cf = a[0]; end
            4'd7: begin
                p = ua * ub;
                e.res = p[15:0];
                e.hi = p[31:16];
                e.hi_wr = 1'b1;
                e.cf = (p[31:16] != 0);
                e.of = e.cf;
                e.multi = 1'b1;
            end
            4'd8: begin
                e.hi_wr = 1'b1;
                if (b == 0) begin
                    e.res = 16'hFFFF;
                    e.hi = a;
                    e.dz = 1'b1;
                end else begin
                    p = ua / ub;
                    e.res = p[15:0];
                    p = ua % ub;
                    e.hi = p[15:0];
                    e.multi = 1'b1;
                end
            end
            default: e.res = 16'h0000;
        endcase
        e.zf = (e.res == 0);
        e.nf = e.res[15];
        return e;
    endfunction

    // Cycle-level model: idle / busy with a countdown / done for one cycle
    bit          m_busy = 0, m_done = 0;
    int          m_wait = 0;
    logic [15:0] m_res = '0, m_hi = '0;
    bit          m_zf = 0, m_nf = 0, m_cf = 0, m_of = 0, m_dz = 0;
    exp_t        m_pend;

    task automatic apply_pend();
        m_res = m_pend.res;
        if (m_pend.hi_wr) m_hi = m_pend.hi;
        m_zf = m_pend.zf; m_nf = m_pend.nf; m_cf = m_pend.cf;
        m_of = m_pend.of; m_dz = m_pend.dz;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_done = 0; m_wait = 0;
            m_res = '0; m_hi = '0;
            m_zf = 0; m_nf = 0; m_cf = 0; m_of = 0; m_dz = 0;
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) begin
                apply_pend();
                m_done = 1;
            end
        end else if (start) begin
            m_pend = model_op(op, ACC_NUM, BR_NUM);
            m_busy = 1;
            if (m_pend.multi) begin
                m_wait = 16;
            end else begin
                apply_pend();
                m_done = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cycle",
                {25'd0, busy, done, ZF, NF, CF, OF, DZ, ALU_hi, ALU_result},
                {25'd0, m_busy, m_done, m_zf, m_nf, m_cf, m_of, m_dz, m_hi, m_res});
        end
    end

    // Issue one operation; inputs are scrambled (and start may toggle) while
    // it is in flight. Returns cycles from start to done and busy count.
    task automatic do_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input bit hold, output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1; op = o; ACC_NUM = a; BR_NUM = b;
        lat = -1;
        nbusy = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            start   = hold ? 1'b1 : 1'($urandom_range(0, 1));
            op      = 4'($urandom);
            ACC_NUM = 16'($urandom);
            BR_NUM  = 16'($urandom);
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got no done expected done within 40 cycles");
        end
    endtask

    function automatic logic [15:0] pick16();
        logic [15:0] sp [5];
        sp[0] = 16'h0000; sp[1] = 16'h0001; sp[2] = 16'h7FFF;
        sp[3] = 16'h8000; sp[4] = 16'hFFFF;
        if ($urandom_range(0, 4) == 0) return sp[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nb;
        exp_t e;
        logic [3:0]  ro;
        logic [15:0] ra, rb;

        rst = 1'b1; start = 1'b0; op = '0; ACC_NUM = '0; BR_NUM = '0;
        #3 rst = 1'b0;
        #1;
        chk("reset_outputs", {25'd0, busy, done, ZF, NF, CF, OF, DZ, ALU_hi, ALU_result}, 64'd0);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases with hand-computed expectations
        do_op(4'd0, 16'h7FFF, 16'h0001, 1'b0, lat, nb);
        chk("add_res", ALU_result, 16'h8000);
        chk("add_flags", {ZF, NF, CF, OF, DZ}, 5'b01010);
        chk("add_lat", lat, 1);

        do_op(4'd1, 16'h0003, 16'h0005, 1'b0, lat, nb);
        chk("sub_res", ALU_result, 16'hFFFE);
        chk("sub_flags", {ZF, NF, CF, OF, DZ}, 5'b01100);

        do_op(4'd1, 16'h1234, 16'h1234, 1'b0, lat, nb);
        chk("sub_zero_res", ALU_result, 16'h0000);
        chk("sub_zero_flags", {ZF, NF, CF, OF, DZ}, 5'b10000);

        do_op(4'd7, 16'h1234, 16'h0100, 1'b1, lat, nb);
        chk("mpy_hi", ALU_hi, 16'h0012);
        chk("mpy_res", ALU_result, 16'h3400);
        chk("mpy_flags", {ZF, NF, CF, OF, DZ}, 5'b00110);
        chk("mpy_lat", lat, 17);
        chk("mpy_busy", nb, 17);

        do_op(4'd8, 16'd100, 16'd7, 1'b0, lat, nb);
        chk("div_res", ALU_result, 16'd14);
        chk("div_hi", ALU_hi, 16'd2);
        chk("div_lat", lat, 17);

        do_op(4'd8, 16'h00AA, 16'h0000, 1'b0, lat, nb);
        chk("divz_res", ALU_result, 16'hFFFF);
        chk("divz_hi", ALU_hi, 16'h00AA);
        chk("divz_flags", {ZF, NF, CF, OF, DZ}, 5'b01001);
        chk("divz_lat", lat, 1);

        do_op(4'd5, 16'h8001, 16'h0000, 1'b0, lat, nb);
        chk("shl_res", ALU_result, 16'h0002);
        chk("shl_flags", {ZF, NF, CF, OF, DZ}, 5'b00100);

        do_op(4'd15, 16'h5555, 16'h3333, 1'b0, lat, nb);
        chk("rsv_res", ALU_result, 16'h0000);
        chk("rsv_hi", ALU_hi, 16'h00AA);
        chk("rsv_flags", {ZF, NF, CF, OF, DZ}, 5'b10000);

        // Reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = 4'd7; ACC_NUM = 16'h00FF; BR_NUM = 16'h0101;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_outputs", {25'd0, busy, done, ZF, NF, CF, OF, DZ, ALU_hi, ALU_result}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        do_op(4'd0, 16'h0001, 16'h0001, 1'b0, lat, nb);
        chk("post_reset_add", ALU_result, 16'h0002);
        chk("post_reset_lat", lat, 1);

        // Randomized operations against the model
        for (int n = 0; n < 150; n++) begin
            ro = 4'($urandom_range(0, 15));
            ra = pick16();
            rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : pick16();
            e  = model_op(ro, ra, rb);
            do_op(ro, ra, rb, 1'($urandom_range(0, 1)), lat, nb);
            chk("rand_lat", lat, e.multi ? 17 : 1);
        end

        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL provide: clk, input, 1, system clock; all state updates on the rising edge.
REQ-002 The block SHALL provide: rst, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL provide: start, input, 1, operation request from the control unit, sampled only in IDLE.
REQ-004 The block SHALL provide: op, input, 4, operation code, sampled with start.
REQ-005 The block SHALL provide: ACC_NUM, input, 16, accumulator operand A, sampled with start.
REQ-006 The block SHALL provide: BR_NUM, input, 16, buffer-register operand B, sampled with start.
REQ-007 The block SHALL provide: ALU_result, output, 16, registered result (low word / quotient); default 0; consumed by the accumulator on its C9 load.
REQ-008 The block SHALL provide: ALU_hi, output, 16, registered high product / remainder; default 0.
REQ-009 The block SHALL provide: busy, output, 1, high in RUN and DONE; default 0.
REQ-010 The block SHALL provide: done, output, 1, one-cycle completion pulse; default 0.
REQ-011 The block SHALL provide: ZF, NF, CF, OF, DZ, outputs, 1 each, registered flags; default 0.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE, with IDLE as the reset state.
REQ-013 In IDLE with start=1, the block SHALL latch op, ACC_NUM and BR_NUM; later input changes SHALL NOT affect the operation in flight.
REQ-014 Single-cycle ops SHALL write ALU_result and the flags on the start edge and go to DONE, so done=1 in the cycle after start.
REQ-015 Single-cycle op 0000 ADD: result = A+B (mod 2^16); CF = carry out of bit 15; OF = signed overflow.
REQ-016 Single-cycle op 0001 SUB: result = A-B (mod 2^16); CF = borrow (A<B unsigned); OF = signed overflow.
REQ-017 Single-cycle op 0010 AND: result = A&B.
REQ-018 Single-cycle op 0011 OR: result = A|B.
REQ-019 Single-cycle op 0100 NOT: result = ~A.
REQ-020 Single-cycle op 0101 SHL: result = A<<1; CF = A[15].
REQ-021 Single-cycle op 0110 SHR (logical): result = A>>1; CF = A[0].
REQ-022 Logic and shift ops SHALL clear OF; logic ops SHALL also clear CF.
REQ-023 Op 0111 MPY SHALL be a 16-iteration unsigned shift-add: {ALU_hi,ALU_result} = A*B, with CF = OF = (ALU_hi != 0).
REQ-024 Op 1000 DIV SHALL be a 16-iteration unsigned restoring divide: ALU_result = quotient, ALU_hi = remainder, CF = OF = 0.
REQ-025 For MPY and DIV, the start edge SHALL enter RUN with a 4-bit iteration counter at 0; each RUN edge performs one iteration.
REQ-026 For MPY and DIV, the edge with counter = 15 SHALL write the results and flags and go to DONE, so done=1 in cycle 17 after start.
REQ-027 DIV with B = 0 SHALL complete in a single cycle with ALU_result = 16'hFFFF, ALU_hi = A and DZ = 1; otherwise DZ SHALL be 0 on every completion.
REQ-028 Ops 1001-1111 SHALL complete in a single cycle with ALU_result = 0, ALU_hi unchanged and all flags 0 except ZF = 1.
REQ-029 On every completion, ZF SHALL be (ALU_result == 0) and NF SHALL be ALU_result[15].
REQ-030 ALU_hi SHALL change only on MPY and DIV completions.
REQ-031 DONE SHALL always go to IDLE on the next edge; start in RUN or DONE SHALL be ignored and not queued.
REQ-032 Outputs SHALL hold their last values between completions, so a falling-edge consumer can load ALU_result in any cycle after done.
REQ-033 Intermediate RUN values SHALL NOT be visible on ALU_result or ALU_hi.

Reset
REQ-034 rst=0 SHALL immediately, regardless of clk, force IDLE, counter 0, and ALU_result, ALU_hi, busy, done and all flags to 0.
REQ-035 A reset during RUN SHALL abort the operation with no completion and no done pulse.
REQ-036 After rst returns to 1, the first start SHALL behave as from power-up.

Verification
REQ-037 ADD with A=16'h7FFF, B=16'h0001 -> ALU_result=16'h8000, OF=1, NF=1, CF=0, ZF=0, done high exactly 1 cycle after start.
REQ-038 SUB with A=16'h0003, B=16'h0005 -> ALU_result=16'hFFFE, CF=1, NF=1; SUB with A=B=16'h1234 -> ALU_result=0, ZF=1.
REQ-039 MPY with A=16'h1234, B=16'h0100 -> ALU_hi=16'h0012, ALU_result=16'h3400, CF=OF=1, busy for 17 cycles, done in cycle 17, and a second start issued mid-RUN is ignored.
REQ-040 DIV with A=100, B=7 -> ALU_result=14, ALU_hi=2 after 17 cycles; DIV with A=16'h00AA, B=0 -> ALU_result=16'hFFFF, ALU_hi=16'h00AA, DZ=1, done after 1 cycle.
REQ-041 Start MPY, assert rst at RUN iteration 8 -> all outputs 0 at once, no done pulse; then ADD with A=1, B=1 -> ALU_result=2.
REQ-042 SHL with A=16'h8001 -> ALU_result=16'h0002, CF=1; op 1111 -> ALU_result=0, ZF=1, ALU_hi keeps its prior value.
